// File: rtl/regbank_pkg.sv
// Shared types for the register-bank access controller.
// RMW_ADD support is selected by REGBANK_CTRL_RMW_EN.
package regbank_pkg;

  localparam int RB_ADDR_W = 5;
  localparam int RB_DATA_W = 32;

  typedef enum logic [1:0] {
    OP_READ    = 2'b00,
    OP_WRITE   = 2'b01,
    OP_RMW_ADD = 2'b10,
    OP_RSVD    = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RMW_RD,
    ST_RMW_WR
  } state_e;

  typedef struct packed {
    logic [RB_DATA_W-1:0] rdata;
    logic                 err;
  } rsp_t;

endpackage

// File: rtl/regbank_rsp_buf.sv
// Two-entry ordered response FIFO.
// Accepts a push while full only when a pop happens in the same cycle.
module regbank_rsp_buf
  import regbank_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  rsp_t push_data,
  input  logic pop,
  output rsp_t pop_data,
  output logic full,
  output logic empty,
  output logic one_free
);

  logic [1:0] cnt;
  logic       wr_ptr;
  logic       rd_ptr;
  rsp_t       mem [2];
  logic       do_push;
  logic       do_pop;

  assign empty    = (cnt == 2'd0);
  assign one_free = (cnt == 2'd1);
  assign full     = (cnt == 2'd2);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt <= cnt + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/regbank_access_ctrl.sv
// Command-to-register-bank controller with buffered responses.
// Define REGBANK_CTRL_RMW_EN to enable RMW_ADD; otherwise it is refused.
module regbank_access_ctrl
  import regbank_pkg::*;
#(
  parameter int ADDR_W = RB_ADDR_W,
  parameter int DATA_W = RB_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              bk_en,
  output logic [ADDR_W-1:0] bk_write_reg,
  output logic [DATA_W-1:0] bk_write_data,
  output logic [ADDR_W-1:0] bk_read_reg,
  input  logic [DATA_W-1:0] bk_read_data,
  output logic              busy
);

  state_e            state_q, state_d;
  op_e               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] rd_reg_q;
  logic              accept;
  logic              addr_zero;
  logic              push;
  rsp_t              push_rsp;
  rsp_t              pop_rsp;
  logic              buf_full;
  logic              buf_empty;
  logic              buf_one_free;
  logic              unused_full;

`ifdef REGBANK_CTRL_RMW_EN
  logic [DATA_W-1:0] sum_q;
`endif

  assign unused_full = buf_full;
  assign addr_zero   = (addr_q == '0);
  assign cmd_ready   = !rst && (state_q == ST_IDLE)
                     && (buf_empty || buf_one_free);
  assign accept      = cmd_valid && cmd_ready;
  assign busy        = (state_q != ST_IDLE) || !buf_empty;
  assign bk_read_reg  = rd_reg_q;
  assign bk_write_reg = addr_q;

`ifdef REGBANK_CTRL_RMW_EN
  assign bk_write_data = (state_q == ST_RMW_WR) ? sum_q : wdata_q;
`else
  assign bk_write_data = wdata_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= OP_READ;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_reg_q <= '0;
    end else if (accept) begin
      op_q    <= op_e'(cmd_op);
      addr_q  <= cmd_addr;
      wdata_q <= cmd_wdata;
      if (cmd_op == OP_READ || cmd_op == OP_RMW_ADD) begin
        rd_reg_q <= cmd_addr;
      end
    end
  end

`ifdef REGBANK_CTRL_RMW_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else if (state_q == ST_RMW_RD) begin
      sum_q <= bk_read_data + wdata_q;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    bk_en    = 1'b0;
    push     = 1'b0;
    push_rsp = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_EXEC;
`ifdef REGBANK_CTRL_RMW_EN
          if (cmd_op == OP_RMW_ADD && cmd_addr != '0) begin
            state_d = ST_RMW_RD;
          end
`endif
        end
      end
      ST_EXEC: begin
        push    = 1'b1;
        state_d = ST_IDLE;
        unique case (op_q)
          OP_READ: begin
            push_rsp.rdata = addr_zero ? '0 : bk_read_data;
          end
          OP_WRITE: begin
            if (addr_zero) begin
              push_rsp.err = 1'b1;
            end else begin
              bk_en          = 1'b1;
              push_rsp.rdata = wdata_q;
            end
          end
          default: begin
            push_rsp.err = 1'b1;
          end
        endcase
      end
`ifdef REGBANK_CTRL_RMW_EN
      ST_RMW_RD: begin
        state_d = ST_RMW_WR;
      end
      ST_RMW_WR: begin
        bk_en          = 1'b1;
        push           = 1'b1;
        push_rsp.rdata = sum_q;
        state_d        = ST_IDLE;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  regbank_rsp_buf u_rsp_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_rsp),
    .pop       (rsp_ready),
    .pop_data  (pop_rsp),
    .full      (buf_full),
    .empty     (buf_empty),
    .one_free  (buf_one_free)
  );

  assign rsp_valid = !buf_empty;
  assign rsp_rdata = pop_rsp.rdata;
  assign rsp_err   = pop_rsp.err;

endmodule

// File: tb/tb_regbank_access_ctrl.sv
// Directed bench for regbank_access_ctrl with a behavioural 32x32 bank.
// Honours REGBANK_CTRL_RMW_EN the same way as the design.
module tb_regbank_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        bk_en;
  logic [4:0]  bk_write_reg;
  logic [31:0] bk_write_data;
  logic [4:0]  bk_read_reg;
  logic [31:0] bk_read_data;
  logic        busy;

  logic [31:0] mem [32];
  int          en_cnt = 0;
  int          checks = 0;
  int          failures = 0;

`ifdef REGBANK_CTRL_RMW_EN
  localparam logic [31:0] R7_FINAL = 32'h0000_0001;
`else
  localparam logic [31:0] R7_FINAL = 32'hFFFF_FFFF;
`endif

  always #5 clk = ~clk;

  assign bk_read_data = mem[bk_read_reg];

  always @(posedge clk) begin
    if (bk_en) begin
      en_cnt <= en_cnt + 1;
      if (bk_write_reg != 5'd0) mem[bk_write_reg] <= bk_write_data;
    end
  end

  regbank_access_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .bk_en         (bk_en),
    .bk_write_reg  (bk_write_reg),
    .bk_write_data (bk_write_data),
    .bk_read_reg   (bk_read_reg),
    .bk_read_data  (bk_read_data),
    .busy          (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns 1ns after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [4:0] a,
                       input logic [31:0] d);
    int n = 0;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    if (!cmd_ready) chk("accept_timeout", 0, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input int lat,
                            input logic [31:0] d, input logic e);
    for (int i = 0; i < lat; i++) begin
      chk({tag, "_early"}, rsp_valid, 0);
      tick();
    end
    chk({tag, "_valid"}, rsp_valid, 1);
    chk({tag, "_rdata"}, rsp_rdata, d);
    chk({tag, "_err"}, rsp_err, e);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_drained"}, rsp_valid, 0);
  endtask

  initial begin
    int en0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_addr  = 5'd0;
    cmd_wdata = 32'h0;
    rsp_ready = 1'b0;
    repeat (2) tick();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_bk_en", bk_en, 0);
    chk("rst_outs", {bk_read_reg, bk_write_reg, bk_write_data}, 0);
    rst = 1'b0;
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_ready", cmd_ready, 1);

    // WRITE then READ r5
    en0 = en_cnt;
    issue(2'b01, 5'd5, 32'hDEAD_BEEF);
    chk("wr5_en", bk_en, 1);
    chk("wr5_reg", bk_write_reg, 5);
    chk("wr5_data", bk_write_data, 32'hDEAD_BEEF);
    expect_rsp("wr5", 1, 32'hDEAD_BEEF, 0);
    chk("wr5_pulse", en_cnt - en0, 1);
    chk("wr5_mem", mem[5], 32'hDEAD_BEEF);
    issue(2'b00, 5'd5, 32'h0);
    chk("rd5_rreg", bk_read_reg, 5);
    expect_rsp("rd5", 1, 32'hDEAD_BEEF, 0);

    // register 0
    mem[0] = 32'hBAD0_BAD0;
    en0 = en_cnt;
    issue(2'b01, 5'd0, 32'h1234);
    chk("wr0_en", bk_en, 0);
    expect_rsp("wr0", 1, 32'h0, 1);
    chk("wr0_nopulse", en_cnt - en0, 0);
    issue(2'b00, 5'd0, 32'h0);
    expect_rsp("rd0", 1, 32'h0, 0);
    mem[0] = 32'h0;

    // RMW wraps modulo 2**32
    issue(2'b01, 5'd7, 32'hFFFF_FFFF);
    expect_rsp("wr7", 1, 32'hFFFF_FFFF, 0);
    en0 = en_cnt;
    issue(2'b10, 5'd7, 32'h2);
`ifdef REGBANK_CTRL_RMW_EN
    chk("rmw_rd_en", bk_en, 0);
    chk("rmw_rreg", bk_read_reg, 7);
    tick();
    chk("rmw_wr_en", bk_en, 1);
    chk("rmw_wr_data", bk_write_data, 32'h1);
    chk("rmw_early", rsp_valid, 0);
    expect_rsp("rmw7", 1, 32'h1, 0);
    chk("rmw_pulse", en_cnt - en0, 1);
`else
    chk("rmw_off_en", bk_en, 0);
    expect_rsp("rmw7", 1, 32'h0, 1);
    chk("rmw_off_pulse", en_cnt - en0, 0);
`endif
    issue(2'b00, 5'd7, 32'h0);
    expect_rsp("rd7", 1, R7_FINAL, 0);

    // Backpressure: two buffered, third held off
    issue(2'b00, 5'd5, 32'h0);
    issue(2'b00, 5'd7, 32'h0);
    tick();
    tick();
    chk("full_ready", cmd_ready, 0);
    chk("full_busy", busy, 1);
    chk("full_rsp0", rsp_rdata, 32'hDEAD_BEEF);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("pop1_rsp", rsp_rdata, R7_FINAL);
    chk("pop1_ready", cmd_ready, 1);
    issue(2'b00, 5'd0, 32'h0);
    tick();
    rsp_ready = 1'b1;
    chk("ord2_valid", rsp_valid, 1);
    chk("ord2_rdata", rsp_rdata, R7_FINAL);
    tick();
    chk("ord3_valid", rsp_valid, 1);
    chk("ord3_rdata", rsp_rdata, 32'h0);
    tick();
    rsp_ready = 1'b0;
    chk("ord_empty", rsp_valid, 0);

    // Reserved op to r3
    mem[3] = 32'h0000_00AA;
    en0 = en_cnt;
    issue(2'b11, 5'd3, 32'h5555);
    chk("rsvd_en", bk_en, 0);
    expect_rsp("rsvd", 1, 32'h0, 1);
    chk("rsvd_mem", mem[3], 32'h0000_00AA);
    chk("rsvd_nopulse", en_cnt - en0, 0);

    // Reset during the RMW read phase
    issue(2'b01, 5'd9, 32'h55);
    expect_rsp("wr9", 1, 32'h55, 0);
    issue(2'b00, 5'd5, 32'h0);
    tick();
    en0 = en_cnt;
    issue(2'b10, 5'd9, 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_en", bk_en, 0);
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_ready", cmd_ready, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_nopulse", en_cnt - en0, 0);
    chk("post_rst_mem", mem[9], 32'h55);
    issue(2'b00, 5'd9, 32'h0);
    expect_rsp("rd9", 1, 32'h55, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
